// File: rtl/n_term_cfg_loopback.sv
// North-edge terminator tile: returns each N-bound wire group to its S-bound twin
// through a per-group mode (combinational, registered, const 0, const 1) and counts Ci rising edges.
module n_term_cfg_loopback #(
    parameter int W1              = 4,
    parameter int W2              = 8,
    parameter int W4              = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int CFG_FRAME       = 0
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic [W1-1:0]              N1END,
    input  logic [W2-1:0]              N2MID,
    input  logic [W2-1:0]              N2END,
    input  logic [W4-1:0]              N4END,
    input  logic                       Ci,
    output logic [W1-1:0]              S1BEG,
    output logic [W2-1:0]              S2BEG,
    output logic [W2-1:0]              S2BEGb,
    output logic [W4-1:0]              S4BEG,
    output logic [7:0]                 CiCnt
);

    localparam logic [1:0] MODE_COMB = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_ZERO = 2'b10;
    localparam logic [1:0] MODE_ONE  = 2'b11;

    logic [7:0]    cfg;
    logic [W1-1:0] s1_q;
    logic [W2-1:0] s2_q;
    logic [W2-1:0] s2b_q;
    logic [W4-1:0] s4_q;
    logic          ci_q;
    logic          cfg_wr;
    logic          cnt_clr;
    logic          ci_rise;
    logic          unused_frame;

    assign cfg_wr  = FrameStrobe[CFG_FRAME];
    assign cnt_clr = cfg_wr & FrameData[8];
    assign ci_rise = Ci & ~ci_q;

    // Upper frame bits and the other strobes belong to neighbouring config cells.
    assign unused_frame = ^{FrameData, FrameStrobe};

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            cfg <= 8'h00;
        end else if (cfg_wr) begin
            cfg <= FrameData[7:0];
        end
    end

    // NOTE: these datapath registers are reset too, so a later switch into
    // registered mode can never expose power-up garbage.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s2b_q <= '0;
            s4_q  <= '0;
        end else begin
            s1_q  <= N1END;
            s2_q  <= N2MID;
            s2b_q <= N2END;
            s4_q  <= N4END;
        end
    end

    // NOTE: non-blocking assignments here so ci_q and the counter both use the
    // pre-edge value of ci_q when detecting a rising edge.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            ci_q  <= 1'b0;
            CiCnt <= 8'h00;
        end else begin
            ci_q <= Ci;
            if (cnt_clr) begin
                CiCnt <= 8'h00;
            end else if (ci_rise && CiCnt != 8'hFF) begin
                CiCnt <= CiCnt + 8'd1;
            end
        end
    end

    // NOTE: each output gets its pass-through default before the case, so no
    // path through these blocks can leave it unassigned and infer a latch.
    always_comb begin
        S1BEG = N1END;
        case (cfg[1:0])
            MODE_REG:  S1BEG = s1_q;
            MODE_ZERO: S1BEG = '0;
            MODE_ONE:  S1BEG = '1;
            default:   S1BEG = N1END;
        endcase
    end

    always_comb begin
        S2BEG = N2MID;
        case (cfg[3:2])
            MODE_REG:  S2BEG = s2_q;
            MODE_ZERO: S2BEG = '0;
            MODE_ONE:  S2BEG = '1;
            default:   S2BEG = N2MID;
        endcase
    end

    always_comb begin
        S2BEGb = N2END;
        case (cfg[5:4])
            MODE_REG:  S2BEGb = s2b_q;
            MODE_ZERO: S2BEGb = '0;
            MODE_ONE:  S2BEGb = '1;
            default:   S2BEGb = N2END;
        endcase
    end

    always_comb begin
        S4BEG = N4END;
        case (cfg[7:6])
            MODE_REG:  S4BEG = s4_q;
            MODE_ZERO: S4BEG = '0;
            MODE_ONE:  S4BEG = '1;
            default:   S4BEG = N4END;
        endcase
    end

    // Comb mode constant kept for readability of the mode table.
    logic unused_mode_comb;
    assign unused_mode_comb = ^MODE_COMB;

endmodule

// File: tb/tb_n_term_cfg_loopback.sv
// Self-checking bench for n_term_cfg_loopback: a behavioural model pushes expected
// outputs to a scoreboard as stimulus is driven; samples are popped and compared.
module tb_n_term_cfg_loopback;

    logic        UserCLK;
    logic        resetn;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [3:0]  N1END;
    logic [7:0]  N2MID;
    logic [7:0]  N2END;
    logic [15:0] N4END;
    logic        Ci;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG;
    logic [7:0]  S2BEGb;
    logic [15:0] S4BEG;
    logic [7:0]  CiCnt;

    n_term_cfg_loopback dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .N1END       (N1END),
        .N2MID       (N2MID),
        .N2END       (N2END),
        .N4END       (N4END),
        .Ci          (Ci),
        .S1BEG       (S1BEG),
        .S2BEG       (S2BEG),
        .S2BEGb      (S2BEGb),
        .S4BEG       (S4BEG),
        .CiCnt       (CiCnt)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    typedef struct {
        logic [3:0]  s1;
        logic [7:0]  s2;
        logic [7:0]  s2b;
        logic [15:0] s4;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_cfg;
    logic [3:0]  m_s1_q;
    logic [7:0]  m_s2_q;
    logic [7:0]  m_s2b_q;
    logic [15:0] m_s4_q;
    logic        m_ci_q;
    logic [7:0]  m_cnt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] m, input logic [15:0] d,
                                         input logic [15:0] q, input logic [15:0] ones);
        case (m)
            2'b00:   return d;
            2'b01:   return q;
            2'b10:   return 16'h0000;
            default: return ones;
        endcase
    endfunction

    task automatic model_reset();
        m_cfg   = 8'h00;
        m_s1_q  = '0;
        m_s2_q  = '0;
        m_s2b_q = '0;
        m_s4_q  = '0;
        m_ci_q  = 1'b0;
        m_cnt   = 8'h00;
    endtask

    // Model update for one rising edge, using the inputs held across it.
    task automatic model_clock();
        if (!resetn) begin
            model_reset();
        end else begin
            m_s1_q  = N1END;
            m_s2_q  = N2MID;
            m_s2b_q = N2END;
            m_s4_q  = N4END;
            if (FrameStrobe[0] && FrameData[8]) m_cnt = 8'h00;
            else if (Ci && !m_ci_q && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_ci_q = Ci;
            if (FrameStrobe[0]) m_cfg = FrameData[7:0];
        end
    endtask

    task automatic expect_now(input string label);
        exp_t e;
        logic [15:0] t;
        t = pick(m_cfg[1:0], {12'h000, N1END}, {12'h000, m_s1_q}, 16'h000F); e.s1 = t[3:0];
        t = pick(m_cfg[3:2], {8'h00, N2MID}, {8'h00, m_s2_q}, 16'h00FF);     e.s2 = t[7:0];
        t = pick(m_cfg[5:4], {8'h00, N2END}, {8'h00, m_s2b_q}, 16'h00FF);    e.s2b = t[7:0];
        t = pick(m_cfg[7:6], N4END, m_s4_q, 16'hFFFF);                       e.s4 = t;
        e.cnt = m_cnt;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check({label, ":sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            e = sb.pop_front();
            check({label, ":S1BEG"},  16'(S1BEG),  16'(e.s1));
            check({label, ":S2BEG"},  16'(S2BEG),  16'(e.s2));
            check({label, ":S2BEGb"}, 16'(S2BEGb), 16'(e.s2b));
            check({label, ":S4BEG"},  S4BEG,       e.s4);
            check({label, ":CiCnt"},  16'(CiCnt),  16'(e.cnt));
        end
    endtask

    // One cycle: drive at the falling edge, check mid-cycle, advance across the rising edge.
    task automatic step(input string label, input logic [3:0] n1, input logic [7:0] n2m,
                        input logic [7:0] n2e, input logic [15:0] n4, input logic ci,
                        input logic [19:0] strobe, input logic [8:0] fd);
        logic [31:0] junk;
        @(negedge UserCLK);
        junk        = $urandom();
        N1END       = n1;
        N2MID       = n2m;
        N2END       = n2e;
        N4END       = n4;
        Ci          = ci;
        FrameStrobe = strobe;
        FrameData   = {junk[31:9], fd};
        expect_now(label);
        @(posedge UserCLK);
        model_clock();
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        resetn      = 1'b0;
        FrameData   = '0;
        FrameStrobe = '0;
        N1END       = 4'hA;
        N2MID       = 8'h3C;
        N2END       = 8'hC3;
        N4END       = 16'h1234;
        Ci          = 1'b0;

        #3;
        expect_now("t1_rst");
        check("t1_S1_const", 16'(S1BEG), 16'h000A);
        check("t1_S4_const", S4BEG, 16'h1234);
        check("t1_cnt_zero", 16'(CiCnt), 16'h0000);

        // Strobe and Ci edge while held in reset must be ignored
        step("t1_rst_wr", 4'h6, 8'h11, 8'h22, 16'h4321, 1'b1, 20'h00001, 9'h1FF);
        #2 resetn = 1'b1;

        // Registered S2 path
        step("t2_wr", 4'h5, 8'h00, 8'h11, 16'hABCD, 1'b0, 20'h00001, 9'h004);
        step("t2_a",  4'h5, 8'h5A, 8'h22, 16'hABCD, 1'b0, 20'h00000, 9'h000);
        step("t2_b",  4'h9, 8'h5A, 8'h33, 16'hABCD, 1'b0, 20'h00000, 9'h000);
        #2 check("t2_lat", 16'(S2BEG), 16'h005A);

        // Constant modes on S2b and S4
        step("t3_wr", 4'h3, 8'h12, 8'h34, 16'h5678, 1'b0, 20'h00001, 9'h0E0);
        step("t3_a",  4'h7, 8'h9A, 8'hBC, 16'hDEF0, 1'b0, 20'h00000, 9'h000);
        step("t3_b",  4'h1, 8'h0F, 8'hF0, 16'h0000, 1'b0, 20'h00000, 9'h000);
        #2 check("t3_S4_ones", S4BEG, 16'hFFFF);

        // Foreign frame strobe leaves config alone
        step("t4_wr", 4'h2, 8'h44, 8'h55, 16'h6666, 1'b0, 20'h00002, 9'h0FF);
        step("t4_a",  4'hE, 8'h77, 8'h88, 16'h9999, 1'b0, 20'h00000, 9'h000);

        // Mixed random traffic with occasional config writes
        for (int i = 0; i < 24; i++) begin
            r = $urandom();
            step("rand", r[3:0], r[11:4], r[19:12], {r[15:0] ^ r[31:16]}, r[20],
                 (i % 5 == 0) ? 20'h00001 : 20'h00000, r[29:21]);
        end

        // Clear counter, then saturate it
        step("t5_clr0", 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0, 20'h00001, {1'b1, m_cfg});
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            step("t5_tog", r[3:0], r[11:4], r[19:12], r[31:16], (i % 2 == 0),
                 20'h00000, 9'h000);
        end
        #2 check("t5_sat", 16'(CiCnt), 16'h00FF);
        step("t5_hold", 4'h1, 8'h01, 8'h02, 16'h0003, 1'b0, 20'h00000, 9'h000);
        step("t5_coinc", 4'h1, 8'h01, 8'h02, 16'h0003, 1'b1, 20'h00001, {1'b1, m_cfg});
        #2 check("t5_clr_wins", 16'(CiCnt), 16'h0000);
        step("t5_after", 4'h1, 8'h01, 8'h02, 16'h0003, 1'b0, 20'h00000, 9'h000);

        // All registered, accumulate a few edges, then asynchronous reset mid-cycle
        step("t6_wr", 4'h3, 8'h21, 8'h43, 16'h6587, 1'b0, 20'h00001, 9'h055);
        step("t6_a",  4'hC, 8'hA1, 8'hB2, 16'hC3D4, 1'b1, 20'h00000, 9'h000);
        step("t6_b",  4'h4, 8'h15, 8'h26, 16'h3748, 1'b0, 20'h00000, 9'h000);
        step("t6_c",  4'hB, 8'hE9, 8'hF8, 16'h0A1B, 1'b1, 20'h00000, 9'h000);
        #1;
        N1END = 4'h6;
        N2MID = 8'h7E;
        N2END = 8'h81;
        N4END = 16'hBEEF;
        #1 resetn = 1'b0;
        model_reset();
        expect_now("t6_rst");
        check("t6_S4_pass", S4BEG, 16'hBEEF);
        #1 resetn = 1'b1;
        step("t6_post", 4'h8, 8'h18, 8'h81, 16'hCAFE, 1'b0, 20'h00000, 9'h000);
        step("t6_rewr", 4'h2, 8'h33, 8'h44, 16'h5555, 1'b0, 20'h00001, 9'h055);
        step("t6_reg",  4'hD, 8'h66, 8'h77, 16'h8888, 1'b0, 20'h00000, 9'h000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
